// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the ExceptioNull fetch-stage program counter.
//   PC_OP_W : width of the pc_op select bus
//   pc_op_t : operation encoding driven on pc_op (codes 5-7 act as NEXT)
// ---------------------------------------------------------------------------
package pc_pkg;

    localparam int PC_OP_W = 3;

    typedef enum logic [PC_OP_W-1:0] {
        PC_NEXT   = 3'd0,
        PC_BRANCH = 3'd1,
        PC_JUMP   = 3'd2,
        PC_CALL   = 3'd3,
        PC_RET    = 3'd4
    } pc_op_t;

endpackage

// File: rtl/pc_ras.sv
// ---------------------------------------------------------------------------
// pc_ras
// Circular return-address stack used by pc_unit for CALL/RET.
// A push onto a full stack overwrites the oldest entry; a pop from an empty
// stack leaves it untouched. Both cases raise a sticky flag that only the
// asynchronous startup reset clears.
//
// Parameters: PC_W (entry width), RAS_DEPTH (entries, >= 2)
// Ports:
//   clk        in   rising-edge clock
//   startup    in   asynchronous active-high reset
//   push       in   store push_data as the new top (already stall-gated)
//   pop        in   discard the top entry (already stall-gated)
//   push_data  in   return address to store
//   top        out  most recently pushed entry (combinational)
//   count      out  number of valid entries
//   overflow   out  sticky: push seen while full
//   underflow  out  sticky: pop seen while empty
// ---------------------------------------------------------------------------
module pc_ras
    import pc_pkg::*;
#(
    parameter int PC_W      = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             startup,
    input  logic                             push,
    input  logic                             pop,
    input  logic [PC_W-1:0]                  push_data,
    output logic [PC_W-1:0]                  top,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   count,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0]  mem [RAS_DEPTH];
    logic [PTR_W-1:0] sp;
    logic [PTR_W-1:0] sp_inc;
    logic [PTR_W-1:0] sp_dec;
    logic             full;
    logic             empty;

    // sp always names the slot the next push writes; once the stack is full
    // that slot holds the oldest entry, which is exactly what gets evicted.
    assign full   = (count == CNT_W'(RAS_DEPTH));
    assign empty  = (count == '0);
    assign sp_inc = (sp == PTR_W'(RAS_DEPTH - 1)) ? '0 : sp + PTR_W'(1);
    assign sp_dec = (sp == '0) ? PTR_W'(RAS_DEPTH - 1) : sp - PTR_W'(1);
    assign top    = mem[sp_dec];

    // Entry storage has no reset: contents are meaningless while count is 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[sp] <= push_data;
        end
    end

    // Pointer, occupancy and sticky error flags.
    always_ff @(posedge clk or posedge startup) begin
        if (startup) begin
            sp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (push) begin
            sp <= sp_inc;
            if (full) begin
                overflow <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end else if (pop) begin
            if (empty) begin
                underflow <= 1'b1;
            end else begin
                sp    <= sp_dec;
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
// Program counter for the ExceptioNull fetch stage: sequential advance,
// conditional PC-relative branch, absolute jump, and CALL/RET through an
// optional hardware return-address stack. All arithmetic wraps mod 2^PC_W.
//
// Build option: define PC_RAS_EN to instantiate the return-address stack.
// Without it CALL acts as JUMP, RET acts as NEXT and the stack outputs are 0.
//
// Parameters: PC_W, RAS_DEPTH (>= 2), RESET_PC
// Ports:
//   clk            in   rising-edge clock
//   startup        in   asynchronous active-high reset
//   stall          in   hold pc, stack and flags; pc_op ignored
//   pc_op          in   operation select (pc_op_t)
//   cond           in   taken qualifier for BRANCH
//   offset         in   two's-complement branch offset
//   target         in   absolute target for JUMP/CALL
//   pc             out  current PC (registered)
//   ras_count      out  valid stack entries
//   ras_overflow   out  sticky: CALL with full stack
//   ras_underflow  out  sticky: RET with empty stack
// ---------------------------------------------------------------------------
module pc_unit
    import pc_pkg::*;
#(
    parameter int              PC_W      = 8,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic                             clk,
    input  logic                             startup,
    input  logic                             stall,
    input  logic [PC_OP_W-1:0]               pc_op,
    input  logic                             cond,
    input  logic [PC_W-1:0]                  offset,
    input  logic [PC_W-1:0]                  target,
    output logic [PC_W-1:0]                  pc,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_overflow,
    output logic                             ras_underflow
);

    pc_op_t          op;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_next;

    assign op     = pc_op_t'(pc_op);
    assign pc_inc = pc + PC_W'(1);

`ifdef PC_RAS_EN
    logic            ras_push;
    logic            ras_pop;
    logic [PC_W-1:0] ras_top;

    // The return address pushed is pc+1; stall masks stack activity so the
    // stack holds in step with the PC register.
    pc_ras #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .startup   (startup),
        .push      (ras_push & ~stall),
        .pop       (ras_pop & ~stall),
        .push_data (pc_inc),
        .top       (ras_top),
        .count     (ras_count),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );
`else
    assign ras_count     = '0;
    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;
`endif

    // Next-PC select. Offset is added as a raw PC_W-bit value: modulo
    // arithmetic makes that identical to a sign-extended add.
    always_comb begin
        pc_next = pc_inc;
`ifdef PC_RAS_EN
        ras_push = 1'b0;
        ras_pop  = 1'b0;
`endif
        case (op)
            PC_BRANCH: begin
                if (cond) begin
                    pc_next = pc_inc + offset;
                end
            end
            PC_JUMP: begin
                pc_next = target;
            end
            PC_CALL: begin
                pc_next = target;
`ifdef PC_RAS_EN
                ras_push = 1'b1;
`endif
            end
            PC_RET: begin
`ifdef PC_RAS_EN
                // An empty-stack return falls through to pc+1.
                ras_pop = 1'b1;
                if (ras_count != '0) begin
                    pc_next = ras_top;
                end
`endif
            end
            default: begin
                pc_next = pc_inc;
            end
        endcase
    end

    // PC register.
    always_ff @(posedge clk or posedge startup) begin
        if (startup) begin
            pc <= RESET_PC;
        end else if (!stall) begin
            pc <= pc_next;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit
// Self-checking bench for pc_unit (PC_W=8, RAS_DEPTH=4, RESET_PC=0).
// A queue-based reference model tracks the expected PC, stack and flags.
// ---------------------------------------------------------------------------
module tb_pc_unit;

    localparam int PC_W      = 8;
    localparam int RAS_DEPTH = 4;
    localparam int CNT_W     = $clog2(RAS_DEPTH + 1);

    logic             clk;
    logic             startup;
    logic             stall;
    logic [2:0]       pc_op;
    logic             cond;
    logic [PC_W-1:0]  offset;
    logic [PC_W-1:0]  target;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] ras_count;
    logic             ras_overflow;
    logic             ras_underflow;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [PC_W-1:0] m_pc;
    logic [PC_W-1:0] m_ras[$];
    logic            m_ovf;
    logic            m_unf;

    pc_unit #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH),
        .RESET_PC  (8'h00)
    ) dut (
        .clk           (clk),
        .startup       (startup),
        .stall         (stall),
        .pc_op         (pc_op),
        .cond          (cond),
        .offset        (offset),
        .target        (target),
        .pc            (pc),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void model_reset();
        m_pc = 8'h00;
        m_ras.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    function automatic logic [CNT_W-1:0] m_count();
`ifdef PC_RAS_EN
        return CNT_W'(m_ras.size());
`else
        return '0;
`endif
    endfunction

    // Drive one operation, let one rising edge pass, advance the model,
    // and leave time 1 unit past the edge for sampling.
    task automatic step(input int op, input bit c, input logic [7:0] off,
                        input logic [7:0] tgt, input bit st);
        pc_op  = 3'(op);
        cond   = c;
        offset = off;
        target = tgt;
        stall  = st;
        @(posedge clk);
        if (!st) begin
            case (op)
                1: m_pc = c ? m_pc + 8'd1 + off : m_pc + 8'd1;
                2: m_pc = tgt;
                3: begin
`ifdef PC_RAS_EN
                    if (m_ras.size() == RAS_DEPTH) begin
                        void'(m_ras.pop_front());
                        m_ovf = 1'b1;
                    end
                    m_ras.push_back(m_pc + 8'd1);
`endif
                    m_pc = tgt;
                end
                4: begin
`ifdef PC_RAS_EN
                    if (m_ras.size() == 0) begin
                        m_unf = 1'b1;
                        m_pc  = m_pc + 8'd1;
                    end else begin
                        m_pc = m_ras.pop_back();
                    end
`else
                    m_pc = m_pc + 8'd1;
`endif
                end
                default: m_pc = m_pc + 8'd1;
            endcase
        end
        #1;
        stall = 1'b0;
    endtask

    // Short reset pulse placed between clock edges.
    task automatic pulse_reset();
        startup = 1'b1;
        #2;
        startup = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        startup = 1'b1;
        stall   = 1'b0;
        pc_op   = 3'd0;
        cond    = 1'b0;
        offset  = '0;
        target  = '0;
        model_reset();
        #12;
        checks++;
        if (pc !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_pc: got %h expected 00", pc);
        end
        checks++;
        if (ras_count !== '0) begin
            errors++;
            $display("[TB] FAIL reset_count: got %0d expected 0", ras_count);
        end
        checks++;
        if ({ras_overflow, ras_underflow} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 00", {ras_overflow, ras_underflow});
        end
        startup = 1'b0;
    endtask

    task automatic test_advance();
        logic [7:0] exp_pc [3];
        exp_pc = '{8'h01, 8'h02, 8'h03};
        for (int i = 0; i < 3; i++) begin
            step(0, 1'b0, 8'h00, 8'h00, 1'b0);
            checks++;
            if (pc !== exp_pc[i]) begin
                errors++;
                $display("[TB] FAIL advance_%0d: got %h expected %h", i, pc, exp_pc[i]);
            end
        end
    endtask

    task automatic test_branch();
        step(2, 1'b0, 8'h00, 8'h05, 1'b0);
        step(1, 1'b1, 8'hFE, 8'h00, 1'b0);
        checks++;
        if (pc !== 8'h04) begin
            errors++;
            $display("[TB] FAIL branch_taken: got %h expected 04", pc);
        end
        step(2, 1'b0, 8'h00, 8'h05, 1'b0);
        step(1, 1'b0, 8'hFE, 8'h00, 1'b0);
        checks++;
        if (pc !== 8'h06) begin
            errors++;
            $display("[TB] FAIL branch_not_taken: got %h expected 06", pc);
        end
        step(1, 1'b1, 8'h10, 8'h00, 1'b0);
        checks++;
        if (pc !== 8'h17) begin
            errors++;
            $display("[TB] FAIL branch_forward: got %h expected 17", pc);
        end
    endtask

    task automatic test_wrap_stall();
        step(2, 1'b0, 8'h00, 8'hFF, 1'b0);
        step(0, 1'b0, 8'h00, 8'h00, 1'b0);
        checks++;
        if (pc !== 8'h00) begin
            errors++;
            $display("[TB] FAIL wrap: got %h expected 00", pc);
        end
        for (int i = 0; i < 3; i++) begin
            step(2, 1'b0, 8'h00, 8'h77, 1'b1);
            checks++;
            if (pc !== 8'h00) begin
                errors++;
                $display("[TB] FAIL stall_hold_%0d: got %h expected 00", i, pc);
            end
        end
    endtask

    task automatic test_call_return();
        step(2, 1'b0, 8'h00, 8'h10, 1'b0);
        step(3, 1'b0, 8'h00, 8'h40, 1'b0);
        checks++;
        if (pc !== 8'h40 || ras_count !== m_count()) begin
            errors++;
            $display("[TB] FAIL call: got pc=%h cnt=%0d expected pc=40 cnt=%0d", pc, ras_count, m_count());
        end
        step(4, 1'b0, 8'h00, 8'h00, 1'b0);
        checks++;
        if (pc !== m_pc || ras_count !== '0) begin
            errors++;
            $display("[TB] FAIL ret: got pc=%h cnt=%0d expected pc=%h cnt=0", pc, ras_count, m_pc);
        end
`ifdef PC_RAS_EN
        checks++;
        if (pc !== 8'h11) begin
            errors++;
            $display("[TB] FAIL ret_addr: got %h expected 11", pc);
        end
`endif
    endtask

    task automatic test_overflow_underflow();
        pulse_reset();
        step(0, 1'b0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(3, 1'b0, 8'h00, 8'(i + 2), 1'b0);
        end
        checks++;
        if (ras_overflow !== m_ovf || ras_count !== m_count()) begin
            errors++;
            $display("[TB] FAIL overflow: got ovf=%b cnt=%0d expected ovf=%b cnt=%0d",
                     ras_overflow, ras_count, m_ovf, m_count());
        end
        for (int i = 0; i < 5; i++) begin
            step(4, 1'b0, 8'h00, 8'h00, 1'b0);
            checks++;
            if (pc !== m_pc || ras_count !== m_count() || ras_underflow !== m_unf) begin
                errors++;
                $display("[TB] FAIL ret_seq_%0d: got pc=%h cnt=%0d unf=%b expected pc=%h cnt=%0d unf=%b",
                         i, pc, ras_count, ras_underflow, m_pc, m_count(), m_unf);
            end
        end
`ifdef PC_RAS_EN
        checks++;
        if (pc !== 8'h04 || ras_underflow !== 1'b1 || ras_overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL underflow: got pc=%h unf=%b ovf=%b expected pc=04 unf=1 ovf=1",
                     pc, ras_underflow, ras_overflow);
        end
`endif
    endtask

    task automatic test_async_reset();
        step(4, 1'b0, 8'h00, 8'h00, 1'b0);
        step(3, 1'b0, 8'h00, 8'h80, 1'b0);
        startup = 1'b1;
        #2;
        checks++;
        if (pc !== 8'h00 || ras_count !== '0 || ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: got pc=%h cnt=%0d ovf=%b unf=%b expected 00/0/0/0",
                     pc, ras_count, ras_overflow, ras_underflow);
        end
        startup = 1'b0;
        model_reset();
        step(0, 1'b0, 8'h00, 8'h00, 1'b0);
        checks++;
        if (pc !== 8'h01) begin
            errors++;
            $display("[TB] FAIL post_reset_next: got %h expected 01", pc);
        end
    endtask

    task automatic test_random();
        int op;
        for (int i = 0; i < 400; i++) begin
            op = (($urandom % 4) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
            step(op, 1'(($urandom % 2)), 8'($urandom), 8'($urandom), ($urandom % 5) == 0);
            checks++;
            if (pc !== m_pc || ras_count !== m_count() ||
                ras_overflow !== m_ovf || ras_underflow !== m_unf) begin
                errors++;
                $display("[TB] FAIL random_%0d op=%0d: got pc=%h cnt=%0d ovf=%b unf=%b expected pc=%h cnt=%0d ovf=%b unf=%b",
                         i, op, pc, ras_count, ras_overflow, ras_underflow,
                         m_pc, m_count(), m_ovf, m_unf);
            end
            if (i == 200) begin
                pulse_reset();
            end
        end
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            step(3, 1'b0, 8'h00, 8'(8'h20 + i), 1'b0);
            step(4, 1'b0, 8'h00, 8'h00, 1'b0);
            checks++;
            if (pc !== m_pc || ras_count !== m_count()) begin
                errors++;
                $display("[TB] FAIL b2b_%0d: got pc=%h cnt=%0d expected pc=%h cnt=%0d",
                         i, pc, ras_count, m_pc, m_count());
            end
        end
    endtask

    initial begin
        test_reset();
        test_advance();
        test_branch();
        test_wrap_stall();
        test_call_return();
        test_async_reset();
        test_overflow_underflow();
        test_back_to_back();
        test_random();
        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program counter for the ExceptioNull core fetch stage. Generates the next instruction address each cycle. Supports sequential advance, conditional PC-relative branch, absolute jump, and call/return through a hardware return-address stack (RAS). Adds stall, configurable width and reset vector, and sticky stack-error flags.

## Interface

- `PC_W`, 8, PC and address width in bits.
- `RAS_DEPTH`, 4, return-address stack entries (≥2).
- `RESET_PC`, 0, PC value loaded on reset.

- `clk`  in  1  rising-edge clock.
- `startup`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hold all state this cycle.
- `pc_op`  in  3  operation select (see Operation).
- `cond`  in  1  branch-taken qualifier for BRANCH.
- `offset`  in  PC_W  two's-complement branch offset.
- `target`  in  PC_W  absolute target for JUMP/CALL.
- `pc`  out  PC_W  current PC, registered.
- `ras_count`  out  $clog2(RAS_DEPTH+1)  valid RAS entries.
- `ras_overflow`  out  1  sticky: CALL issued with RAS full.
- `ras_underflow`  out  1  sticky: RET issued with RAS empty.

## Operation

- `pc_op` encoding:
  - 0 NEXT: pc+1.
  - 1 BRANCH: pc+1+offset if `cond`, else pc+1.
  - 2 JUMP: target.
  - 3 CALL: push pc+1, then pc←target.
  - 4 RET: pc←top of stack, pop.
  - 5–7: treated as NEXT.
- Arithmetic is modulo 2^PC_W. Offset is sign-interpreted, so 0xFF wraps to 0 and offset 0xFE is −2. No overflow detection on the PC itself.
- `stall`=1: pc, RAS contents, count and flags all hold. `pc_op` is ignored.
- RAS is a circular LIFO.
  - CALL when full: the oldest entry is overwritten, the push still occurs, `ras_count` stays RAS_DEPTH, and `ras_overflow` is set.
  - RET when empty: pc←pc+1, `ras_count` stays 0, and `ras_underflow` is set.
- Sticky flags clear only on `startup`.
- Reset state (asynchronous, any time, including mid-operation):
  - pc=RESET_PC.
  - ras_count=0.
  - Both flags 0.
  - RAS contents don't-care.

## Timing

- Next-PC logic is combinational from current inputs and state. `pc` updates at the rising edge, giving 1-cycle latency from op to new `pc`.
- `startup` assertion forces outputs to reset values immediately, without waiting for `clk`.
- The first op is applied at the first rising edge after `startup` deasserts.
- A CALL's pushed address is visible to a RET issued in the very next cycle. Back-to-back CALL/RET is legal at full rate.
- `ras_count` and flags update on the same edge as `pc`.

## Configuration

- `PC_RAS_EN` defined: RAS, `ras_count`, and both flags are implemented as above.
- Not defined:
  - No stack storage is instantiated.
  - CALL behaves as JUMP, with no push.
  - RET behaves as NEXT.
  - `ras_count`, `ras_overflow` and `ras_underflow` are tied to 0.

## Structure

- Shared package `pc_pkg` holds:
  - `pc_op_t` enum (PC_NEXT, PC_BRANCH, PC_JUMP, PC_CALL, PC_RET).
  - The op width constant (3).
- Sub-module `pc_ras` (params PC_W, RAS_DEPTH):
  - Ports: push, pop, push_data, top, count, overflow, underflow.
  - Contains the circular pointer and count logic.
  - Instantiated only under `PC_RAS_EN`.
- `pc_unit` holds the PC register and next-PC mux.

## Test plan

1. Reset vector and advance: `startup` pulse → pc=0x00. Then three NEXT → pc 0x01, 0x02, 0x03.
2. Branch: pc=0x05, BRANCH, offset=0xFE, cond=1 → 0x04. Same with cond=0 → 0x06.
3. Wrap: pc=0xFF, NEXT → 0x00. Then stall=1 for 3 cycles with pc_op=JUMP → pc holds 0x00.
4. Call/return: at pc=0x10, CALL target=0x40 → pc=0x40, ras_count=1. Next cycle RET → pc=0x11, ras_count=0.
5. Overflow/underflow (RAS_DEPTH=4):
   - 5 CALLs from pcs 0x01–0x05 → ras_overflow=1.
   - 4 RETs → 0x06, 0x05, 0x04, 0x03.
   - 5th RET → pc+1 and ras_underflow=1.
6. Async reset mid-stream: assert `startup` between edges after step 4 → pc=0x00, ras_count=0, flags 0 before the next edge.
